// File: rtl/shader_in_arb.sv
// Two-input ray arbiter feeding one registered shader input stage.
// Secondary rays win contention for at most MAX_SEC grants in a row.
module shader_in_arb #(
    parameter int unsigned DW      = 211,
    parameter int unsigned MAX_SEC = 8,
    parameter int unsigned CW      = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          prg_valid,
    input  logic [DW-1:0] prg_data,
    output logic          prg_stall,

    input  logic          sec_valid,
    input  logic [DW-1:0] sec_data,
    output logic          sec_stall,

    input  logic          shader_stall,
    output logic          shader_valid,
    output logic [DW-1:0] shader_data,
    output logic          shader_src,

    output logic [31:0]   prg_issued,
    output logic [31:0]   sec_issued
);

    if (MAX_SEC > (1 << CW) - 1) begin : g_bad_params
        $error("shader_in_arb: MAX_SEC does not fit in CW bits");
    end

    logic          load_en;
    logic          sec_wins;
    logic          grant_prg;
    logic          grant_sec;
    logic          grant_any;
    logic [CW-1:0] streak;
    logic [CW-1:0] streak_d;

    // The output register can take a new ray when empty or being drained.
    assign load_en  = ~shader_valid | ~shader_stall;
    assign sec_wins = (streak < CW'(MAX_SEC));

    assign grant_sec = load_en & sec_valid & (~prg_valid | sec_wins);
    assign grant_prg = load_en & prg_valid & ~(sec_valid & sec_wins);
    assign grant_any = grant_sec | grant_prg;

    assign prg_stall = ~grant_prg;
    assign sec_stall = ~grant_sec;

    // A sec grant with prg_valid high is necessarily contested.
    always_comb begin
        streak_d = streak;
        if (!prg_valid || grant_prg) begin
            streak_d = '0;
        end else if (grant_sec && sec_wins) begin
            streak_d = streak + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else begin
            streak <= streak_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shader_valid <= 1'b0;
            shader_data  <= '0;
            shader_src   <= 1'b0;
        end else if (load_en) begin
            shader_valid <= grant_any;
            if (grant_any) begin
                shader_data <= grant_sec ? sec_data : prg_data;
                shader_src  <= grant_sec;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prg_issued <= '0;
            sec_issued <= '0;
        end else begin
            if (grant_prg) prg_issued <= prg_issued + 32'd1;
            if (grant_sec) sec_issued <= sec_issued + 32'd1;
        end
    end

endmodule

// File: tb/tb_shader_in_arb.sv
// Scoreboard bench for shader_in_arb: directed traffic, hand-listed source
// order, monitor pops expected rays whenever the output is consumed.
module tb_shader_in_arb;
    localparam int unsigned DW      = 211;
    localparam int unsigned MAX_SEC = 8;
    localparam int unsigned CW      = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prg_valid = 1'b0;
    logic [DW-1:0] prg_data = '0;
    logic          prg_stall;
    logic          sec_valid = 1'b0;
    logic [DW-1:0] sec_data = '0;
    logic          sec_stall;
    logic          shader_stall = 1'b0;
    logic          shader_valid;
    logic [DW-1:0] shader_data;
    logic          shader_src;
    logic [31:0]   prg_issued;
    logic [31:0]   sec_issued;

    shader_in_arb #(.DW(DW), .MAX_SEC(MAX_SEC), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .prg_valid    (prg_valid),
        .prg_data     (prg_data),
        .prg_stall    (prg_stall),
        .sec_valid    (sec_valid),
        .sec_data     (sec_data),
        .sec_stall    (sec_stall),
        .shader_stall (shader_stall),
        .shader_valid (shader_valid),
        .shader_data  (shader_data),
        .shader_src   (shader_src),
        .prg_issued   (prg_issued),
        .sec_issued   (sec_issued)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned prg_idx = 0, sec_idx = 0;
    int unsigned exp_p = 0, exp_s = 0;
    logic [DW:0] exp_q[$];
    logic        pacc, sacc;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    function automatic logic [DW-1:0] mk(input bit s, input int unsigned i);
        logic [31:0] v;
        v = (s ? 32'h5EC0_0000 : 32'h0A11_0000) + i;
        return DW'(v);
    endfunction

    // Queue the next expected ray from a source; returns its payload.
    task automatic push(input bit s, output logic [DW-1:0] d);
        if (s) begin d = mk(1'b1, exp_s); exp_s++; end
        else   begin d = mk(1'b0, exp_p); exp_p++; end
        exp_q.push_back({s, d});
    endtask

    task automatic push_n(input bit s, input int n);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) push(s, d);
    endtask

    task automatic drive(input bit pv, input bit sv, input bit st);
        prg_valid    = pv;
        sec_valid    = sv;
        shader_stall = st;
        prg_data     = mk(1'b0, prg_idx);
        sec_data     = mk(1'b1, sec_idx);
        #2;
        pacc = pv & ~prg_stall;
        sacc = sv & ~sec_stall;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pacc) prg_idx++;
        if (sacc) sec_idx++;
    endtask

    task automatic cyc(input bit pv, input bit sv, input bit st, input int n);
        for (int i = 0; i < n; i++) begin
            drive(pv, sv, st);
            step();
        end
    endtask

    task automatic do_reset();
        prg_valid = 1'b0; sec_valid = 1'b0; shader_stall = 1'b0;
        rst = 1'b1;
        #2;
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: every consumed output must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && shader_valid && !shader_stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {shader_src, shader_data}, '1);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("out_src", 256'(shader_src), 256'(e[DW]));
                chk("out_data", 256'(shader_data), 256'(e[DW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        // Reset state, with stalls tracking grant readiness during reset.
        prg_valid = 1'b1;
        #3;
        chk("rst_valid", 256'(shader_valid), 256'(0));
        chk("rst_data", 256'(shader_data), 256'(0));
        chk("rst_src", 256'(shader_src), 256'(0));
        chk("rst_prg_cnt", 256'(prg_issued), 256'(0));
        chk("rst_sec_cnt", 256'(sec_issued), 256'(0));
        chk("rst_prg_stall", 256'(prg_stall), 256'(0));
        chk("rst_sec_stall", 256'(sec_stall), 256'(1));
        do_reset();

        // Primary only for 5 cycles.
        push_n(1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            chk("prg_only_stall", 256'(prg_stall), 256'(0));
            step();
        end
        cyc(1'b0, 1'b0, 1'b0, 2);
        chk("prg_only_cnt", 256'(prg_issued), 256'(5));

        // Contested for 20 cycles: 8 sec, 1 prg, 8 sec, 1 prg, 2 sec.
        do_reset();
        push_n(1'b1, 8); push_n(1'b0, 1); push_n(1'b1, 8); push_n(1'b0, 1); push_n(1'b1, 2);
        cyc(1'b1, 1'b1, 1'b0, 20);
        cyc(1'b0, 1'b0, 1'b0, 2);
        chk("contest_sec_cnt", 256'(sec_issued), 256'(18));
        chk("contest_prg_cnt", 256'(prg_issued), 256'(2));

        // Stall with a ray held, then release.
        do_reset();
        push(1'b0, held);
        push_n(1'b1, 1);
        cyc(1'b1, 1'b0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1);
            chk("stall_data", 256'(shader_data), 256'(held));
            chk("stall_prg", 256'(prg_stall), 256'(1));
            chk("stall_sec", 256'(sec_stall), 256'(1));
            step();
        end
        chk("stall_prg_cnt", 256'(prg_issued), 256'(1));
        chk("stall_sec_cnt", 256'(sec_issued), 256'(0));
        cyc(1'b0, 1'b1, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0);
        chk("release_next_valid", 256'(shader_valid), 256'(1));
        chk("release_next_src", 256'(shader_src), 256'(1));
        step();
        cyc(1'b0, 1'b0, 1'b0, 1);

        // prg_valid drops mid-streak: streak restarts, 8 more sec before prg.
        do_reset();
        push_n(1'b1, 5); push_n(1'b1, 1); push_n(1'b1, 8); push_n(1'b0, 1);
        cyc(1'b1, 1'b1, 1'b0, 5);
        cyc(1'b0, 1'b1, 1'b0, 1);
        cyc(1'b1, 1'b1, 1'b0, 9);
        cyc(1'b0, 1'b0, 1'b0, 2);
        chk("drop_sec_cnt", 256'(sec_issued), 256'(14));
        chk("drop_prg_cnt", 256'(prg_issued), 256'(1));

        // Reset while holding a stalled ray: ray discarded.
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1);
        exp_p++;
        cyc(1'b1, 1'b0, 1'b1, 1);
        chk("pre_rst_valid", 256'(shader_valid), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 256'(shader_valid), 256'(0));
        chk("mid_rst_data", 256'(shader_data), 256'(0));
        chk("mid_rst_prg_cnt", 256'(prg_issued), 256'(0));
        prg_valid = 1'b0; shader_stall = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 2);

        // Counter wrap: preload sec_issued to all ones, then one sec grant.
        do_reset();
        force dut.sec_issued = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.sec_issued;
        chk("wrap_preload", 256'(sec_issued), 256'(32'hFFFF_FFFF));
        push_n(1'b1, 1);
        cyc(1'b0, 1'b1, 1'b0, 1);
        chk("wrap_sec_cnt", 256'(sec_issued), 256'(0));
        cyc(1'b0, 1'b0, 1'b0, 2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1'b0, 1'b0, 1'b0, 1);
        chk("queue_drained", 256'(exp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/shader_in_arb.md
SHADER_IN_ARB -- requirements
Module: shader_in_arb

Interface
REQ-001 The block SHALL have parameter DW, default 211, giving the ray payload width in bits for both requesters.
REQ-002 The block SHALL have parameter MAX_SEC, default 8, giving the maximum number of consecutive contested secondary-ray grants.
REQ-003 The block SHALL have parameter CW, default 4, giving the streak counter width; MAX_SEC SHALL be at most 2^CW-1.
REQ-004 The block SHALL have port clk, input, 1 bit: clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port prg_valid, input, 1 bit: a primary ray is offered.
REQ-007 The block SHALL have port prg_data, input, DW bits: the primary ray payload.
REQ-008 The block SHALL have port prg_stall, output, 1 bit: the primary ray is not accepted this cycle.
REQ-009 The block SHALL have port sec_valid, input, 1 bit: a secondary ray is offered.
REQ-010 The block SHALL have port sec_data, input, DW bits: the secondary ray payload.
REQ-011 The block SHALL have port sec_stall, output, 1 bit: the secondary ray is not accepted this cycle.
REQ-012 The block SHALL have port shader_stall, input, 1 bit: the shader refuses the output.
REQ-013 The block SHALL have port shader_valid, output, 1 bit: the output register holds a ray.
REQ-014 The block SHALL have port shader_data, output, DW bits: the registered ray payload.
REQ-015 The block SHALL have port shader_src, output, 1 bit: source of the held ray (0 = primary, 1 = secondary).
REQ-016 The block SHALL have port prg_issued, output, 32 bits: count of accepted primary rays, wrapping.
REQ-017 The block SHALL have port sec_issued, output, 32 bits: count of accepted secondary rays, wrapping.

Function
REQ-018 The block SHALL hold a single output register stage (shader_valid, shader_data, shader_src); load_en = ~shader_valid | ~shader_stall.
REQ-019 When shader_valid=1 and shader_stall=1, the block SHALL hold shader_data and shader_src stable.
REQ-020 The block SHALL grant only when load_en=1, and SHALL grant at most one requester per cycle.
REQ-021 When only one requester is valid, the block SHALL grant that requester.
REQ-022 When both requesters are valid (contested), the block SHALL grant sec if streak < MAX_SEC, and prg otherwise.
REQ-023 The streak counter SHALL increment on a contested sec grant and SHALL saturate at MAX_SEC.
REQ-024 The streak counter SHALL clear to 0 on any prg grant, and on any cycle with prg_valid=0.
REQ-025 prg_stall SHALL be ~(load_en & grant_prg), combinational; sec_stall SHALL be ~(load_en & grant_sec), combinational; a stall deasserted while valid=0 is harmless.
REQ-026 On a grant, the block SHALL load the granted data and source into the output register at the next clk edge and set shader_valid=1 (latency 1 cycle).
REQ-027 When load_en=1 and no grant occurs, the block SHALL clear shader_valid at the next edge.
REQ-028 On simultaneous consume and grant, the block SHALL take the new ray back-to-back with no bubble (throughput 1 ray/cycle).
REQ-029 prg_issued SHALL increment on each prg grant; sec_issued SHALL increment on each sec grant; both SHALL wrap modulo 2^32.
REQ-030 The block SHALL never drop or duplicate a ray: each accepted ray appears exactly once at the output, with shader_valid=1 and shader_stall=0.

Reset
REQ-031 While rst=1, the block SHALL asynchronously force shader_valid=0, shader_data=0, shader_src=0, streak=0, prg_issued=0 and sec_issued=0.
REQ-032 While rst=1, prg_stall and sec_stall SHALL still follow REQ-025; with shader_valid=0 they reflect grant readiness.
REQ-033 Reset asserted mid-stall SHALL discard the held ray.
REQ-034 The first grant after reset release SHALL occur on the first clk edge with rst=0.

Verification
REQ-035 Scenario: only prg_valid=1 for 5 cycles, shader_stall=0 -> 5 outputs with src=0, prg_issued=5, prg_stall=0 throughout.
REQ-036 Scenario: both valid for 20 cycles, MAX_SEC=8, no stall -> output src pattern is 8 sec, 1 prg, repeating; sec_issued=18, prg_issued=2.
REQ-037 Scenario: shader_stall=1 for 4 cycles with a ray held -> shader_data stable, both stalls=1, counters unchanged; on release, the next ray follows on the next cycle.
REQ-038 Scenario: prg_valid drops for 1 cycle mid-streak (streak=5) -> streak=0, so 8 more contested sec grants occur before the next prg grant.
REQ-039 Scenario: rst pulsed while shader_valid=1 and stalled -> shader_valid=0, counters=0 immediately, and the ray is not emitted.
REQ-040 Scenario: sec_issued preloaded via force to 32'hFFFFFFFF, then one sec grant -> sec_issued=0.
